// File: rtl/rom_upload_reader.sv
// HPS upload read-back responder: serves 16-bit ioctl reads from DDRAM through a
// single 64-bit line cache, using the toggle req/ack handshake on the ddram read side.
module rom_upload_reader #(
  parameter int unsigned ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              RESET_N,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [15:0]       ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_rdaddr,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [63:0]       mem_dout
);

  localparam int unsigned TAG_W = ADDR_W - 3;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [63:0]      line;
  logic [TAG_W-1:0] tag;
  logic             valid;
  logic             upload_q;
  logic [1:0]       lane_q;

  logic             upload_rise_c;
  logic [TAG_W-1:0] addr_tag_c;
  logic             hit_c;
  logic             ack_c;
  logic             unused_addr_lsb;

  // Word reads only: the byte-select bit carries no information.
  assign unused_addr_lsb = ioctl_addr[0];

  assign upload_rise_c = ioctl_upload & ~upload_q;
  assign addr_tag_c    = ioctl_addr[ADDR_W-1:3];
  // A new session invalidates the line before a coincident read can hit it.
  assign hit_c         = valid & ~upload_rise_c & (tag == addr_tag_c);
  assign ack_c         = (mem_rd_ack == mem_rd_req);

  // Pick one 16-bit lane and undo the download byte swap.
  function automatic logic [15:0] lane_swap(input logic [63:0] d, input logic [1:0] k);
    logic [15:0] l;
    case (k)
      2'd0:    l = d[15:0];
      2'd1:    l = d[31:16];
      2'd2:    l = d[47:32];
      default: l = d[63:48];
    endcase
    return {l[7:0], l[15:8]};
  endfunction

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_INIT;
      line       <= 64'd0;
      tag        <= TAG_W'(0);
      valid      <= 1'b0;
      upload_q   <= 1'b0;
      lane_q     <= 2'd0;
      ioctl_din  <= 16'd0;
      ioctl_wait <= 1'b0;
      mem_rdaddr <= ADDR_W'(0);
      mem_rd_req <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      if (upload_rise_c) valid <= 1'b0;

      case (state)
        S_INIT: begin
          // Adopt the current ack phase so a stale ack is never taken as new.
          mem_rd_req <= mem_rd_ack;
          state      <= S_IDLE;
        end

        S_IDLE: begin
          if (ioctl_rd && ioctl_upload) begin
            lane_q <= ioctl_addr[2:1];
            if (hit_c) begin
              ioctl_din <= lane_swap(line, ioctl_addr[2:1]);
            end else begin
              ioctl_wait <= 1'b1;
              mem_rdaddr <= {addr_tag_c, 3'b000};
              mem_rd_req <= ~mem_rd_req;
              state      <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (!ioctl_upload) begin
            valid <= 1'b0;
            state <= S_DRAIN;
          end else if (ack_c) begin
            line       <= mem_dout;
            tag        <= mem_rdaddr[ADDR_W-1:3];
            valid      <= 1'b1;
            ioctl_din  <= lane_swap(mem_dout, lane_q);
            ioctl_wait <= 1'b0;
            state      <= S_IDLE;
          end
        end

        S_DRAIN: begin
          // Outstanding toggle cannot be withdrawn; swallow its data.
          if (ack_c) begin
            ioctl_wait <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_upload_reader.sv
// Directed bench for rom_upload_reader: transaction-level cache/memory model,
// a DDRAM toggle responder and a per-cycle steady-state output checker.
module tb_rom_upload_reader;

  logic        clk_sys;
  logic        RESET_N;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;
  logic [24:0] mem_rdaddr;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic [63:0] mem_dout;

  rom_upload_reader #(.ADDR_W(25)) dut (
    .clk_sys      (clk_sys),
    .RESET_N      (RESET_N),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_rdaddr   (mem_rdaddr),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_ack   (mem_rd_ack),
    .mem_dout     (mem_dout)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  int req_toggles = 0;

  bit          steady = 0;
  logic [15:0] exp_din = 16'd0;
  bit          cache_ok = 0;
  logic [21:0] cached_line = 22'd0;

  bit auto_ack = 1;
  int ack_delay = 1;
  int cmd_seq = 0;
  int cmd_kind = 0;
  int done_seq = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Backing store contents, one 64-bit word per 8-byte line.
  function automatic logic [63:0] mem_word(input logic [24:0] a);
    logic [15:0] ln;
    ln = 16'(a[18:3]);
    case (a[24:3])
      22'd0:       return 64'h4444_3333_2222_1111;
      22'd1:       return 64'h0123_4567_89AB_CDEF;
      22'h3FFFFF:  return 64'hCAFE_1234_5678_9ABC;
      default:     return {ln ^ 16'h5A5A, 16'h1357, 16'h2468, ln};
    endcase
  endfunction

  // Expected read data: little-endian 16-bit word at the address, bytes swapped.
  function automatic logic [15:0] model_din(input logic [24:0] a);
    logic [63:0] w;
    logic [15:0] l;
    w = mem_word(a);
    l = 16'(w >> (16 * int'(a[2:1])));
    return {l[7:0], l[15:8]};
  endfunction

  always @(mem_rd_req) req_toggles++;

  // DDRAM responder: acks each outstanding toggle after ack_delay cycles,
  // or executes a one-shot command from the main sequence.
  initial begin
    int pend;
    pend = 0;
    mem_rd_ack = 1'b1;
    mem_dout = 64'd0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (cmd_seq != done_seq) begin
        if (cmd_kind == 1) begin
          mem_dout   = 64'hDEAD_BEEF_F00D_CAFE;
          mem_rd_ack = mem_rd_req;
        end else begin
          mem_rd_ack = 1'b1;
        end
        done_seq = cmd_seq;
        pend = 0;
      end else if (auto_ack && RESET_N && (mem_rd_req !== mem_rd_ack)) begin
        pend++;
        if (pend >= ack_delay) begin
          mem_dout   = mem_word(mem_rdaddr);
          mem_rd_ack = mem_rd_req;
          pend = 0;
        end
      end else begin
        pend = 0;
      end
    end
  end

  // Between transactions the outputs must be idle and hold the last read data.
  always @(negedge clk_sys) begin
    if (steady && RESET_N) begin
      chk("steady_wait", 64'(ioctl_wait), 64'd0);
      chk("steady_din", 64'(ioctl_din), 64'(exp_din));
    end
  end

  task automatic rd(input logic [24:0] a, input bit rise, input bit lit_miss,
                    input logic [15:0] lit_din);
    int t0;
    int n;
    bit miss;
    logic [15:0] m;
    steady = 0;
    @(negedge clk_sys);
    miss = rise || !cache_ok || (cached_line != a[24:3]);
    m = model_din(a);
    chk("model_miss", 64'(miss), 64'(lit_miss));
    chk("model_din", 64'(m), 64'(lit_din));
    t0 = req_toggles;
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    if (rise) ioctl_upload = 1'b1;
    @(posedge clk_sys);
    #1 ioctl_rd = 1'b0;
    @(negedge clk_sys);
    if (miss) begin
      chk("miss_wait", 64'(ioctl_wait), 64'd1);
      chk("miss_toggle", 64'(req_toggles), 64'(t0 + 1));
      chk("miss_rdaddr", 64'(mem_rdaddr), 64'({a[24:3], 3'b000}));
      n = 0;
      while (ioctl_wait && n < 64) begin
        @(negedge clk_sys);
        n++;
      end
      chk("miss_done", 64'(ioctl_wait), 64'd0);
      chk("miss_one_toggle", 64'(req_toggles), 64'(t0 + 1));
      cache_ok = 1;
      cached_line = a[24:3];
    end else begin
      chk("hit_wait", 64'(ioctl_wait), 64'd0);
      chk("hit_no_toggle", 64'(req_toggles), 64'(t0));
    end
    chk("rd_din", 64'(ioctl_din), 64'(m));
    exp_din = m;
    steady = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    RESET_N = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_rd = 1'b0;
    ioctl_addr = 25'd0;

    // Reset state, then INIT adopts ack phase 1.
    repeat (2) @(negedge clk_sys);
    chk("rst_din", 64'(ioctl_din), 64'd0);
    chk("rst_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_rdaddr", 64'(mem_rdaddr), 64'd0);
    chk("rst_req", 64'(mem_rd_req), 64'd0);
    RESET_N = 1'b1;
    @(negedge clk_sys);
    chk("init_resync", 64'(mem_rd_req), 64'd1);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    steady = 1;

    rd(25'h0000000, 0, 1, 16'h1111);
    rd(25'h0000006, 0, 0, 16'h4444);
    ack_delay = 3;
    rd(25'h0000008, 0, 1, 16'hEFCD);
    rd(25'h000000A, 0, 0, 16'hAB89);
    rd(25'h1FFFFFE, 0, 1, 16'hFECA);
    rd(25'h1FFFFF8, 0, 0, 16'hBC9A);
    rd(25'h0000000, 0, 1, 16'h1111);

    // Reads outside an upload session are ignored.
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);
    t0 = req_toggles;
    ioctl_addr = 25'h0000008;
    ioctl_rd = 1'b1;
    @(posedge clk_sys);
    #1 ioctl_rd = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("noupl_toggle", 64'(req_toggles), 64'(t0));
    chk("noupl_din", 64'(ioctl_din), 64'(exp_din));

    // Session start coincident with a read of the cached line: forced refetch.
    rd(25'h0000002, 1, 1, 16'h2222);
    rd(25'h0000004, 0, 0, 16'h3333);

    // Upload drops mid-fetch: drain the late ack, keep old data.
    auto_ack = 0;
    steady = 0;
    @(negedge clk_sys);
    t0 = req_toggles;
    ioctl_addr = 25'h0000040;
    ioctl_rd = 1'b1;
    @(posedge clk_sys);
    #1 ioctl_rd = 1'b0;
    @(negedge clk_sys);
    chk("drain_issue_wait", 64'(ioctl_wait), 64'd1);
    chk("drain_issue_toggle", 64'(req_toggles), 64'(t0 + 1));
    ioctl_upload = 1'b0;
    repeat (5) @(negedge clk_sys);
    chk("drain_hold_wait", 64'(ioctl_wait), 64'd1);
    cmd_kind = 1;
    cmd_seq++;
    n = 0;
    while (ioctl_wait && n < 64) begin
      @(negedge clk_sys);
      n++;
    end
    chk("drain_done", 64'(ioctl_wait), 64'd0);
    chk("drain_din_kept", 64'(ioctl_din), 64'(exp_din));
    cache_ok = 0;
    auto_ack = 1;
    steady = 1;
    repeat (2) @(negedge clk_sys);
    ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    rd(25'h0000000, 0, 1, 16'h1111);

    // Asynchronous reset in the middle of a fetch, with ack phase 1.
    auto_ack = 0;
    steady = 0;
    @(negedge clk_sys);
    t0 = req_toggles;
    ioctl_addr = 25'h0000010;
    ioctl_rd = 1'b1;
    @(posedge clk_sys);
    #1 ioctl_rd = 1'b0;
    @(negedge clk_sys);
    chk("rstf_wait", 64'(ioctl_wait), 64'd1);
    RESET_N = 1'b0;
    cmd_kind = 2;
    cmd_seq++;
    #1;
    chk("rstf_din", 64'(ioctl_din), 64'd0);
    chk("rstf_wait_clr", 64'(ioctl_wait), 64'd0);
    chk("rstf_req", 64'(mem_rd_req), 64'd0);
    repeat (2) @(negedge clk_sys);
    RESET_N = 1'b1;
    @(negedge clk_sys);
    chk("rstf_resync", 64'(mem_rd_req), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      chk("rstf_quiet_wait", 64'(ioctl_wait), 64'd0);
      chk("rstf_quiet_din", 64'(ioctl_din), 64'd0);
    end
    exp_din = 16'd0;
    cache_ok = 0;
    auto_ack = 1;
    steady = 1;
    rd(25'h0000010, 0, 1, 16'h0200);
    chk("rstf_fresh_req", 64'(mem_rd_req), 64'd0);

    steady = 0;
    repeat (2) @(negedge clk_sys);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
